// File: rtl/snd_lpf_mixer.sv
// snd_lpf_mixer
//   Time-multiplexed one-pole IIR low-pass filter and saturating mixer for
//   N PSG channels. One sample frame, started by cen_sample, walks the
//   channels through a two-stage pipeline and produces one mixed sample.
//   Per-channel filter mode is double-buffered (shadow/active) so mode
//   changes take effect only at frame boundaries.
//
// Ports
//   clk_49m      in   system clock
//   reset        in   asynchronous reset, active low
//   cen_sample   in   one-cycle strobe, starts a sample frame
//   ch_in        in   CHANNELS*W signed samples, channel i at [i*W +: W]
//   sel_we       in   write strobe for the shadow filter-select register
//   sel_data     in   CHANNELS*2 mode bits (0 bypass, 1/2/3 = K1/K2/K3)
//   sound        out  W-bit signed saturated mix, registered
//   sound_valid  out  one-cycle pulse when sound updates
//   busy         out  frame in progress (LOAD through OUT)
//   overrun      out  sticky, cen_sample seen while busy
//
// Build option
//   SND_LPF_MIXER_INVERT_EN  when defined, sound = -(saturated sum), clamped
//                            again so that -(-2^(W-1)) becomes 2^(W-1)-1.
//
// state  | meaning
// IDLE   | waiting for cen_sample
// LOAD   | inputs/selects captured, accumulator cleared, idx = 0
// RUN    | one channel enters the pipeline per cycle
// DRAIN1 | last channel completes stage 2
// DRAIN2 | pipeline flush
// OUT    | saturated result registered, sound_valid raised next cycle
module snd_lpf_mixer #(
  parameter int          CHANNELS = 6,
  parameter int          W        = 16,
  parameter logic [15:0] K1       = 16'h3A00,
  parameter logic [15:0] K2       = 16'h0F00,
  parameter logic [15:0] K3       = 16'h0C80
) (
  input  logic                    clk_49m,
  input  logic                    reset,
  input  logic                    cen_sample,
  input  logic [CHANNELS*W-1:0]   ch_in,
  input  logic                    sel_we,
  input  logic [CHANNELS*2-1:0]   sel_data,
  output logic signed [W-1:0]     sound,
  output logic                    sound_valid,
  output logic                    busy,
  output logic                    overrun
);

  localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int AW = W + 4;
  localparam int PW = W + 18;
  localparam int SW = W + 2;
  localparam logic signed [AW-1:0] SMAX = {{5{1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN = {{5{1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN1, S_DRAIN2, S_OUT} state_t;

  state_t state_q, state_d;

  logic [IW-1:0]           idx_q;
  logic [CHANNELS*2-1:0]   sel_shadow, sel_act;
  logic signed [W-1:0]     x_q [CHANNELS];
  logic signed [W-1:0]     y_q [CHANNELS];
  logic signed [AW-1:0]    acc_q;

  logic                    s1_valid, s1_bypass;
  logic [IW-1:0]           s1_idx;
  logic signed [W-1:0]     s1_x, s1_y;
  logic signed [SW-1:0]    s1_step;

  logic                    accept;
  logic signed [W-1:0]     x_cur, y_cur;
  logic [1:0]              mode_cur;
  logic [15:0]             alpha_cur;
  logic signed [W:0]       d_cur;
  logic signed [PW-1:0]    d_w, a_w, prod_cur;
  logic signed [W-1:0]     ch_out;
  logic signed [AW-1:0]    sat_w, res_w;

  assign accept = (state_q == S_IDLE) && cen_sample;
  assign busy   = (state_q != S_IDLE);

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (cen_sample) state_d = S_LOAD;
      S_LOAD:   state_d = S_RUN;
      S_RUN:    if (idx_q == IW'(CHANNELS - 1)) state_d = S_DRAIN1;
      S_DRAIN1: state_d = S_DRAIN2;
      S_DRAIN2: state_d = S_OUT;
      S_OUT:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Stage 1: d = x - y at W+1 bits, scaled by the unsigned Q0.16 alpha.
  always_comb begin
    x_cur    = x_q[idx_q];
    y_cur    = y_q[idx_q];
    mode_cur = sel_act[idx_q*2 +: 2];
    case (mode_cur)
      2'd1:    alpha_cur = K1;
      2'd2:    alpha_cur = K2;
      default: alpha_cur = K3;
    endcase
    d_cur    = {x_cur[W-1], x_cur} - {y_cur[W-1], y_cur};
    d_w      = PW'(d_cur);
    a_w      = PW'({1'b0, alpha_cur});
    prod_cur = d_w * a_w;
  end

  // Stage 2: y stays between old y and x, so W bits always hold the sum.
  assign ch_out = s1_bypass ? s1_x : W'(SW'(s1_y) + s1_step);

  always_comb begin
    if (acc_q > SMAX)      sat_w = SMAX;
    else if (acc_q < SMIN) sat_w = SMIN;
    else                   sat_w = acc_q;
`ifdef SND_LPF_MIXER_INVERT_EN
    res_w = -sat_w;
    if (res_w > SMAX) res_w = SMAX;
`else
    res_w = sat_w;
`endif
  end

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      idx_q       <= '0;
      sel_shadow  <= '0;
      sel_act     <= '0;
      acc_q       <= '0;
      s1_valid    <= 1'b0;
      s1_bypass   <= 1'b0;
      s1_idx      <= '0;
      s1_x        <= '0;
      s1_y        <= '0;
      s1_step     <= '0;
      sound       <= '0;
      sound_valid <= 1'b0;
      overrun     <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      if (sel_we) sel_shadow <= sel_data;
      if (accept) begin
        // same-cycle select write goes straight into this frame
        sel_act <= sel_we ? sel_data : sel_shadow;
        for (int i = 0; i < CHANNELS; i++) x_q[i] <= ch_in[i*W +: W];
      end
      if (busy && cen_sample) overrun <= 1'b1;

      if (state_q == S_LOAD)     idx_q <= '0;
      else if (state_q == S_RUN) idx_q <= idx_q + 1'b1;

      s1_valid  <= (state_q == S_RUN);
      s1_bypass <= (mode_cur == 2'd0);
      s1_idx    <= idx_q;
      s1_x      <= x_cur;
      s1_y      <= y_cur;
      s1_step   <= SW'(prod_cur >>> 16);

      if (state_q == S_LOAD) acc_q <= '0;
      else if (s1_valid) begin
        acc_q         <= acc_q + AW'(ch_out);
        y_q[s1_idx]   <= ch_out;
      end

      sound_valid <= (state_q == S_OUT);
      if (state_q == S_OUT) sound <= W'(res_w);
    end
  end

endmodule

// File: tb/tb_snd_lpf_mixer.sv
module tb_snd_lpf_mixer;

  localparam int          C  = 6;
  localparam int          W  = 16;
  localparam logic [15:0] K1 = 16'h8000;
  localparam logic [15:0] K2 = 16'h0F00;
  localparam logic [15:0] K3 = 16'h0C80;
  localparam longint      VMAX = (longint'(1) <<< (W-1)) - 1;
  localparam longint      VMIN = -(longint'(1) <<< (W-1));

  logic                  clk_49m = 1'b0;
  logic                  reset = 1'b0;
  logic                  cen_sample = 1'b0;
  logic                  sel_we = 1'b0;
  logic [C*W-1:0]        ch_in = '0;
  logic [C*2-1:0]        sel_data = '0;
  logic signed [W-1:0]   sound;
  logic                  sound_valid, busy, overrun;

  snd_lpf_mixer #(.CHANNELS(C), .W(W), .K1(K1), .K2(K2), .K3(K3)) dut (
    .clk_49m(clk_49m), .reset(reset), .cen_sample(cen_sample), .ch_in(ch_in),
    .sel_we(sel_we), .sel_data(sel_data), .sound(sound),
    .sound_valid(sound_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk_49m = ~clk_49m;

  int cyc = 0;
  always @(posedge clk_49m) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { longint val; int cyc; } exp_t;
  exp_t exp_q[$];

  longint           y_m [C];
  logic [C*2-1:0]   shadow_m = '0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint clamp(input longint v);
    if (v > VMAX) return VMAX;
    if (v < VMIN) return VMIN;
    return v;
  endfunction

  // Reference: y += floor((x - y) * alpha / 2^16), bypass tracks x.
  function automatic longint model_frame(input logic [C*W-1:0] xin, input logic [C*2-1:0] modes);
    longint sum, x, d, p, alpha, s;
    logic [1:0] m;
    sum = 0;
    for (int i = 0; i < C; i++) begin
      x = longint'($signed(xin[i*W +: W]));
      m = modes[2*i +: 2];
      if (m == 2'd0) y_m[i] = x;
      else begin
        alpha = (m == 2'd1) ? longint'(K1) : (m == 2'd2) ? longint'(K2) : longint'(K3);
        d = x - y_m[i];
        p = d * alpha;
        y_m[i] = y_m[i] + (p >>> 16);
      end
      sum += y_m[i];
    end
    s = clamp(sum);
`ifdef SND_LPF_MIXER_INVERT_EN
    s = clamp(-s);
`endif
    return s;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk_49m);
    #1;
  endtask

  function automatic logic [C*W-1:0] rand_x();
    logic [C*W-1:0] v;
    for (int i = 0; i < C; i++) v[i*W +: W] = W'($urandom);
    return v;
  endfunction

  function automatic logic [C*W-1:0] all_x(input int val);
    logic [C*W-1:0] v;
    for (int i = 0; i < C; i++) v[i*W +: W] = W'(val);
    return v;
  endfunction

  // Drives one cen_sample cycle, then scrambles ch_in after capture.
  // Returns at 3 cycles after the strobe cycle (mid-RUN).
  task automatic frame_start(input logic [C*W-1:0] x, input bit we_same,
                             input logic [C*2-1:0] sd, input bit push);
    logic [C*2-1:0] act;
    exp_t e;
    ch_in = x;
    cen_sample = 1'b1;
    if (we_same) begin
      sel_we = 1'b1;
      sel_data = sd;
    end
    if (push) begin
      act = we_same ? sd : shadow_m;
      if (we_same) shadow_m = sd;
      e.val = model_frame(x, act);
      e.cyc = cyc + C + 5;
      exp_q.push_back(e);
    end
    tick(1);
    cen_sample = 1'b0;
    sel_we = 1'b0;
    tick(2);
    ch_in = rand_x();
  endtask

  task automatic write_sel(input logic [C*2-1:0] sd);
    sel_data = sd;
    sel_we = 1'b1;
    shadow_m = sd;
    tick(1);
    sel_we = 1'b0;
  endtask

  task automatic frame(input logic [C*W-1:0] x);
    frame_start(x, 1'b0, '0, 1'b1);
    tick(C + 3);
  endtask

  always @(negedge clk_49m) begin
    if (reset && sound_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_valid: got sound_valid=1 with sound %0d, expected no pulse (cycle %0d)", sound, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sound", longint'(sound), e.val);
        check("latency_cycle", longint'(cyc), longint'(e.cyc));
      end
    end
  end

  initial begin
    logic [C*W-1:0] x;
    for (int i = 0; i < C; i++) y_m[i] = 0;

    // reset values
    tick(3);
    check("rst_sound", longint'(sound), 0);
    check("rst_valid", longint'(sound_valid), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_overrun", longint'(overrun), 0);
    reset = 1'b1;
    tick(2);

    // bypass mix, busy during frame
    frame_start(all_x(1000), 1'b0, '0, 1'b1);
    check("busy_mid", longint'(busy), 1);
    tick(C + 3);
    check("busy_after", longint'(busy), 0);

    // saturation both ways
    frame(all_x(16000));
    frame(all_x(-32768));
    tick(4);
    check("sound_hold", longint'(sound), model_frame(all_x(-32768), '0));
    for (int i = 0; i < C; i++) y_m[i] = -32768;

    // IIR step: ch0 mode 1 from zero state
    frame(all_x(0));
    write_sel(12'b00_00_00_00_00_01);
    x = '0;
    x[W-1:0] = W'(1000);
    repeat (4) frame(x);

    // select timing: mid-frame write only affects the following frame
    write_sel('0);
    frame(all_x(2000));
    frame_start(all_x(-3000), 1'b0, '0, 1'b1);
    write_sel(12'b01_01_01_01_01_01);
    tick(C + 2);
    frame(all_x(3000));
    frame_start(all_x(500), 1'b1, '0, 1'b1);
    tick(C + 3);

    // overrun: second strobe 3 cycles into the frame
    check("overrun_before", longint'(overrun), 0);
    frame_start(all_x(1234), 1'b0, '0, 1'b1);
    cen_sample = 1'b1;
    tick(1);
    cen_sample = 1'b0;
    tick(C + 4);
    check("overrun_set", longint'(overrun), 1);
    frame(all_x(-777));
    check("overrun_sticky", longint'(overrun), 1);

    // randomized frames with random modes and select writes
    for (int n = 0; n < 24; n++) begin
      logic [C*2-1:0] sd;
      sd = (C*2)'($urandom);
      case ($urandom_range(0, 2))
        0: begin
          write_sel(sd);
          frame(rand_x());
        end
        1: begin
          frame_start(rand_x(), 1'b1, sd, 1'b1);
          tick(C + 3);
        end
        default: begin
          frame_start(rand_x(), 1'b0, '0, 1'b1);
          write_sel(sd);
          tick(C + 2);
        end
      endcase
    end

    // reset mid-RUN: nothing pushed, outputs cleared at once
    write_sel(12'b11_10_01_11_10_01);
    frame_start(rand_x(), 1'b0, '0, 1'b0);
    tick(1);
    reset = 1'b0;
    #1;
    check("midrst_sound", longint'(sound), 0);
    check("midrst_valid", longint'(sound_valid), 0);
    check("midrst_busy", longint'(busy), 0);
    check("midrst_overrun", longint'(overrun), 0);
    for (int i = 0; i < C; i++) y_m[i] = 0;
    shadow_m = '0;
    tick(3);
    reset = 1'b1;
    tick(C + 6);

    // after reset: selects are bypass, y cleared
    write_sel(12'b00_00_00_00_00_01);
    x = '0;
    x[W-1:0] = W'(1000);
    frame(x);
    write_sel('0);
    frame(all_x(1000));
    check("overrun_cleared", longint'(overrun), 0);

    // drain scoreboard with a bounded wait
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) tick(1);
    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL timeout_valid: got no sound_valid, expected sound %0d at cycle %0d", e.val, e.cyc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
